// File: rtl/lfsr_pkg.sv
// Shared definitions for the 4-bit LFSR checker: state width, the
// x^4+x+1 next-state function and the checker FSM state encoding.
package lfsr_pkg;

    localparam int LFSR_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        LOCKUP = 2'd2
    } state_t;

    // One step of the x^4+x+1 Galois-style register (period 15, zero is a lockup).
    function automatic logic [LFSR_W-1:0] nxt(input logic [LFSR_W-1:0] s);
        return {s[2], s[1], s[3] ^ s[0], s[3]};
    endfunction

endpackage

// File: rtl/lfsr_misr.sv
// Multiple-input signature register: folds every valid sample into the
// running signature using the same polynomial as the monitored LFSR.
module lfsr_misr
    import lfsr_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [LFSR_W-1:0] q,
    output logic [LFSR_W-1:0] sig
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sig <= '0;
        end else if (in_valid) begin
            sig <= nxt(sig) ^ q;
        end
    end

endmodule

// File: rtl/lfsr_checker.sv
// Sequence checker for a 4-bit x^4+x+1 LFSR stream: lock, error count,
// lockup detection and period measurement. MISR signature on sig is built
// only when LFSR_CHECKER_MISR_EN is defined; otherwise sig is tied to zero.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int ERR_W = 8,
    parameter int PER_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [LFSR_W-1:0] q,
    output logic              locked,
    output logic              err,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              lockup,
    output logic [PER_W-1:0]  period,
    output logic              period_valid,
    output logic [LFSR_W-1:0] sig
);

    state_t            state;
    logic [LFSR_W-1:0] exp;
    logic [LFSR_W-1:0] anchor;
    logic [PER_W-1:0]  cnt;
    logic              zero;
    logic              hit;

    function automatic logic [ERR_W-1:0] sat_err(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    function automatic logic [PER_W-1:0] sat_per(input logic [PER_W-1:0] v);
        return (&v) ? v : v + PER_W'(1);
    endfunction

    assign zero = (q == '0);
    assign hit  = (q == exp);

    // anchor holds the sample a period measurement started from; seeing it
    // again on a correct step closes one full trip around the sequence.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state        <= IDLE;
            exp          <= '0;
            anchor       <= '0;
            cnt          <= '0;
            locked       <= 1'b0;
            err          <= 1'b0;
            err_cnt      <= '0;
            lockup       <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
        end else begin
            err <= 1'b0;
            if (in_valid) begin
                if (zero) begin
                    state        <= LOCKUP;
                    lockup       <= 1'b1;
                    locked       <= 1'b0;
                    period_valid <= 1'b0;
                    if (state == TRACK) begin
                        err     <= 1'b1;
                        err_cnt <= sat_err(err_cnt);
                    end
                end else begin
                    case (state)
                        IDLE, LOCKUP: begin
                            state  <= TRACK;
                            lockup <= 1'b0;
                            exp    <= nxt(q);
                            anchor <= q;
                            cnt    <= PER_W'(1);
                        end
                        TRACK: begin
                            exp <= nxt(q);
                            if (hit) begin
                                locked <= 1'b1;
                                if (q == anchor) begin
                                    period       <= cnt;
                                    period_valid <= 1'b1;
                                    cnt          <= PER_W'(1);
                                end else begin
                                    cnt <= sat_per(cnt);
                                end
                            end else begin
                                err          <= 1'b1;
                                err_cnt      <= sat_err(err_cnt);
                                locked       <= 1'b0;
                                period_valid <= 1'b0;
                                anchor       <= q;
                                cnt          <= PER_W'(1);
                            end
                        end
                        default: begin
                            state <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

`ifdef LFSR_CHECKER_MISR_EN
    lfsr_misr u_misr (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .in_valid (in_valid),
        .q        (q),
        .sig      (sig)
    );
`else
    assign sig = '0;
`endif

endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 Parameter ERR_W, default 8, SHALL set the width of the error counter.
REQ-002 Parameter PER_W, default 5, SHALL set the width of the period counter.
REQ-003 clk  in  1  SHALL be the single clock; all state changes on rising edge.
REQ-004 rst  in  1  SHALL be the reset; synchronous, active-high.
REQ-005 clear  in  1  SHALL be a synchronous restart of tracking.
REQ-006 in_valid  in  1  SHALL qualify q as one sample of the upstream 4-bit LFSR.
REQ-007 q  in  4  SHALL carry the LFSR state sample.
REQ-008 locked  out  1  SHALL indicate that the stream is following the LFSR sequence.
REQ-009 err  out  1  SHALL be a one-cycle sequence-error pulse.
REQ-010 err_cnt  out  ERR_W  SHALL be a saturating count of sequence errors.
REQ-011 lockup  out  1  SHALL indicate that an all-zero sample was seen.
REQ-012 period  out  PER_W  SHALL be the measured sequence period.
REQ-013 period_valid  out  1  SHALL indicate that period holds a completed measurement.
REQ-014 sig  out  4  SHALL be the MISR signature (see Configuration).

Function
REQ-015 Next-state function nxt(s) SHALL be: nxt[0]=s[3], nxt[1]=s[3]^s[0], nxt[2]=s[1], nxt[3]=s[2] (x^4+x+1, period 15).
REQ-016 All outputs SHALL be registered and SHALL reflect a sample one cycle after in_valid; no state change without in_valid, except clear.
REQ-017 FSM states SHALL be IDLE, TRACK and LOCKUP; reset enters IDLE.
REQ-018 IDLE + nonzero sample: go to TRACK, set exp=nxt(q) and ref=q, set the period counter to 1; locked stays 0.
REQ-019 TRACK + sample == exp: set locked=1, exp=nxt(q), and increment the period counter (saturates at 2^PER_W-1).
REQ-020 TRACK + correct sample == ref: load period with the counter value, set period_valid=1, and restart the counter at 1.
REQ-021 TRACK + nonzero sample != exp: pulse err, increment err_cnt (saturating), set locked=0 and period_valid=0, then resync: exp=nxt(q), ref=q, counter=1.
REQ-022 Any state + zero sample: go to LOCKUP with lockup=1, locked=0, period_valid=0; err pulses and err_cnt increments only if the state was TRACK.
REQ-023 LOCKUP + nonzero sample: clear lockup and enter TRACK per REQ-018 rules.
REQ-024 clear SHALL return to IDLE and zero locked, err, err_cnt, lockup, period, period_valid and sig; it overrides a simultaneous in_valid.
REQ-025 err_cnt at all-ones SHALL hold; err still pulses.

Reset
REQ-026 rst SHALL have priority over clear and in_valid; it sets state IDLE and all outputs 0.

Configuration
REQ-027 With LFSR_CHECKER_MISR_EN defined, every valid sample SHALL update sig <= nxt(sig) ^ q; this includes samples in IDLE, LOCKUP and error cycles.
REQ-028 Without LFSR_CHECKER_MISR_EN, the port sig SHALL exist, SHALL be tied 4'h0, and no MISR register SHALL exist.

Structure
REQ-029 Shared package lfsr_pkg SHALL hold LFSR_W=4, the nxt() function and the FSM state enum.
REQ-030 Sub-module lfsr_misr SHALL implement the signature register; it is instantiated only under LFSR_CHECKER_MISR_EN.

Verification
REQ-031 Reset, then valid samples F,D,9,1,2,... for 15 correct steps returning to F -> locked=1 after the 2nd sample; period=15 and period_valid=1 one cycle after the 16th sample.
REQ-032 After F, feed 9 instead of D -> err high exactly one cycle, err_cnt=1, locked=0, period_valid=0; next sample nxt(9)=1 -> locked=1.
REQ-033 While in TRACK, feed 0 -> lockup=1, err_cnt+1; then feed 1 -> lockup=0, state TRACK, no further err.
REQ-034 clear and in_valid with a bad sample in the same cycle -> err=0, err_cnt=0, state IDLE.
REQ-035 300 consecutive mismatching samples -> err_cnt=255 (ERR_W=8) and holds at 255.
REQ-036 With the macro: reset, feed F then D -> sig=F, then sig=0; without the macro, sig=0 throughout.
